// File: rtl/sl_sram_arbiter.sv
// rtl/sl_sram_arbiter.sv - two-port round-robin arbiter sharing one single-port SRAM
module sl_sram_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int BURST_LEN = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  // port 0
  input  logic          REQ0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  input  logic [3:0]    WEN0,
  output logic          GNT0,
  output logic          RVALID0,
  output logic [DW-1:0] RDATA0,
  // port 1
  input  logic          REQ1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  input  logic [3:0]    WEN1,
  output logic          GNT1,
  output logic          RVALID1,
  output logic [DW-1:0] RDATA1,
  // SRAM macro
  output logic [AW-1:0] SRAMADDR,
  output logic [DW-1:0] SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS,
  input  logic [DW-1:0] SRAMRDATA
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_owner_q, last_owner_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;

  logic       gnt0_raw, gnt1_raw;
  logic       gnt0, gnt1;
  logic [3:0] cnt_inc;

  // Arbitration: the owner keeps the SRAM until its burst quota is used up while the other port waits
  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ0 && REQ1) begin
          // tie from idle goes to whoever did not own the SRAM last
          if (last_owner_q) gnt0_raw = 1'b1;
          else              gnt1_raw = 1'b1;
        end else begin
          gnt0_raw = REQ0;
          gnt1_raw = REQ1;
        end
      end
      ST_OWN0: begin
        if (REQ0 && ((cnt_q < BURST_MAX) || !REQ1)) gnt0_raw = 1'b1;
        else if (REQ1)                              gnt1_raw = 1'b1;
      end
      ST_OWN1: begin
        if (REQ1 && ((cnt_q < BURST_MAX) || !REQ0)) gnt1_raw = 1'b1;
        else if (REQ0)                              gnt0_raw = 1'b1;
      end
      default: begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
      end
    endcase
    // grants are gated by reset so the SRAM sees no access while HRESETn is low
    gnt0 = gnt0_raw & HRESETn;
    gnt1 = gnt1_raw & HRESETn;
  end

  // Next-state: track owner, saturating burst count and last owner; arm read-data return
  always_comb begin
    state_d      = ST_IDLE;
    cnt_d        = 4'd0;
    last_owner_d = last_owner_q;
    cnt_inc      = (cnt_q < BURST_MAX) ? (cnt_q + 4'd1) : BURST_MAX;
    if (gnt0) begin
      state_d      = ST_OWN0;
      last_owner_d = 1'b0;
      cnt_d        = (state_q == ST_OWN0) ? cnt_inc : 4'd1;
    end else if (gnt1) begin
      state_d      = ST_OWN1;
      last_owner_d = 1'b1;
      cnt_d        = (state_q == ST_OWN1) ? cnt_inc : 4'd1;
    end
    rvalid0_d = gnt0 && (WEN0 == 4'b0000);
    rvalid1_d = gnt1 && (WEN1 == 4'b0000);
  end

  // State register; reset clears any in-flight read return immediately
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_owner_q <= 1'b1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // SRAM drive: mux the granted port; address/data default to port 0 when idle
  always_comb begin
    SRAMCS    = gnt0 | gnt1;
    SRAMADDR  = ADDR0;
    SRAMWDATA = WDATA0;
    SRAMWEN   = 4'b0000;
    if (gnt1) begin
      SRAMADDR  = ADDR1;
      SRAMWDATA = WDATA1;
      SRAMWEN   = WEN1;
    end else if (gnt0) begin
      SRAMWEN   = WEN0;
    end
  end

  // Outputs: grants and read data, zeroed when not valid
  always_comb begin
    GNT0    = gnt0;
    GNT1    = gnt1;
    RVALID0 = rvalid0_q;
    RVALID1 = rvalid1_q;
    RDATA0  = rvalid0_q ? SRAMRDATA : '0;
    RDATA1  = rvalid1_q ? SRAMRDATA : '0;
  end

endmodule

// File: tb/tb_sl_sram_arbiter.sv
// tb/tb_sl_sram_arbiter.sv - randomized self-checking bench for sl_sram_arbiter
module tb_sl_sram_arbiter;

  logic        HCLK;
  logic        HRESETn;
  logic        REQ0, REQ1;
  logic [11:0] ADDR0, ADDR1;
  logic [31:0] WDATA0, WDATA1;
  logic [3:0]  WEN0, WEN1;

  // instance 0 uses BURST_LEN=4, instance 1 uses BURST_LEN=1
  logic [1:0]  gnt0_o, gnt1_o, rv0_o, rv1_o, scs;
  logic [31:0] rd0_o [2];
  logic [31:0] rd1_o [2];
  logic [11:0] saddr [2];
  logic [31:0] swd [2];
  logic [3:0]  swen [2];
  logic [31:0] srd [2];

  logic [31:0] smem0 [4096];
  logic [31:0] smem1 [4096];
  logic [31:0] rmem [2][4096];

  int          owner [2];
  int          run [2];
  int          lastw [2];
  int          bl [2];
  bit          pv [2][2];
  logic [31:0] pd [2][2];
  int          last_g [2];

  int n_tests = 0;
  int n_fail  = 0;

  sl_sram_arbiter #(.AW(12), .DW(32), .BURST_LEN(4)) dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .REQ0(REQ0), .ADDR0(ADDR0), .WDATA0(WDATA0), .WEN0(WEN0),
    .GNT0(gnt0_o[0]), .RVALID0(rv0_o[0]), .RDATA0(rd0_o[0]),
    .REQ1(REQ1), .ADDR1(ADDR1), .WDATA1(WDATA1), .WEN1(WEN1),
    .GNT1(gnt1_o[0]), .RVALID1(rv1_o[0]), .RDATA1(rd1_o[0]),
    .SRAMADDR(saddr[0]), .SRAMWDATA(swd[0]), .SRAMWEN(swen[0]),
    .SRAMCS(scs[0]), .SRAMRDATA(srd[0])
  );

  sl_sram_arbiter #(.AW(12), .DW(32), .BURST_LEN(1)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .REQ0(REQ0), .ADDR0(ADDR0), .WDATA0(WDATA0), .WEN0(WEN0),
    .GNT0(gnt0_o[1]), .RVALID0(rv0_o[1]), .RDATA0(rd0_o[1]),
    .REQ1(REQ1), .ADDR1(ADDR1), .WDATA1(WDATA1), .WEN1(WEN1),
    .GNT1(gnt1_o[1]), .RVALID1(rv1_o[1]), .RDATA1(rd1_o[1]),
    .SRAMADDR(saddr[1]), .SRAMWDATA(swd[1]), .SRAMWEN(swen[1]),
    .SRAMCS(scs[1]), .SRAMRDATA(srd[1])
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // SRAM macros: byte-lane writes, one-cycle read latency
  always @(posedge HCLK) begin
    if (scs[0]) begin
      if (swen[0] == 4'b0000) srd[0] <= smem0[saddr[0]];
      for (int b = 0; b < 4; b++)
        if (swen[0][b]) smem0[saddr[0]][8*b +: 8] <= swd[0][8*b +: 8];
    end
  end

  always @(posedge HCLK) begin
    if (scs[1]) begin
      if (swen[1] == 4'b0000) srd[1] <= smem1[saddr[1]];
      for (int b = 0; b < 4; b++)
        if (swen[1][b]) smem1[saddr[1]][8*b +: 8] <= swd[1][8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arbitration: owner keeps going unless the other side waits and the run hit its limit
  function automatic int exp_grant(input int inst, input bit r0, input bit r1);
    bit want [2];
    int x;
    want[0] = r0;
    want[1] = r1;
    if (owner[inst] < 0) begin
      if (r0 && r1) return 1 - lastw[inst];
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    x = owner[inst];
    if (want[x] && !(want[1-x] && run[inst] >= bl[inst])) return x;
    if (want[1-x]) return 1 - x;
    return -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (w[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1;
      run[i]   = 0;
      lastw[i] = 1;
      pv[i][0] = 1'b0;
      pv[i][1] = 1'b0;
    end
  endtask

  task automatic step(input bit r0, input logic [11:0] a0, input logic [31:0] d0, input logic [3:0] w0,
                      input bit r1, input logic [11:0] a1, input logic [31:0] d1, input logic [3:0] w1);
    int g;
    logic [11:0] ga;
    logic [31:0] gd;
    logic [3:0]  gw;
    REQ0 = r0; ADDR0 = a0; WDATA0 = d0; WEN0 = w0;
    REQ1 = r1; ADDR1 = a1; WDATA1 = d1; WEN1 = w1;
    #1;
    for (int i = 0; i < 2; i++) begin
      g = exp_grant(i, r0, r1);
      last_g[i] = gnt0_o[i] ? 0 : (gnt1_o[i] ? 1 : -1);
      ga = (g == 1) ? a1 : a0;
      gd = (g == 1) ? d1 : d0;
      gw = (g == 1) ? w1 : w0;
      check("gnt0", 32'(gnt0_o[i]), 32'(g == 0));
      check("gnt1", 32'(gnt1_o[i]), 32'(g == 1));
      check("sramcs", 32'(scs[i]), 32'(g >= 0));
      check("sramwen", 32'(swen[i]), (g >= 0) ? 32'(gw) : 32'd0);
      if (g >= 0) check("sramaddr", 32'(saddr[i]), 32'(ga));
      if (g >= 0 && gw != 4'b0000) check("sramwdata", swd[i], gd);
      check("rvalid0", 32'(rv0_o[i]), 32'(pv[i][0]));
      check("rvalid1", 32'(rv1_o[i]), 32'(pv[i][1]));
      check("rdata0", rd0_o[i], pv[i][0] ? pd[i][0] : 32'd0);
      check("rdata1", rd1_o[i], pv[i][1] ? pd[i][1] : 32'd0);
      pv[i][0] = 1'b0;
      pv[i][1] = 1'b0;
      if (g >= 0) begin
        if (gw == 4'b0000) begin
          pv[i][g] = 1'b1;
          pd[i][g] = rmem[i][ga];
        end else begin
          rmem[i][ga] = merge(rmem[i][ga], gd, gw);
        end
        run[i]   = (g == owner[i]) ? ((run[i] + 1 > bl[i]) ? bl[i] : run[i] + 1) : 1;
        owner[i] = g;
        lastw[i] = g;
      end else begin
        owner[i] = -1;
        run[i]   = 0;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 12'h0, 32'h0, 4'h0, 0, 12'h0, 32'h0, 4'h0);
  endtask

  // Drop reset with the current requests held; everything must be quiet immediately
  task automatic pulse_reset();
    HRESETn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_rvalid0", 32'(rv0_o[i]), 32'd0);
      check("rst_rvalid1", 32'(rv1_o[i]), 32'd0);
      check("rst_gnt", 32'({gnt0_o[i], gnt1_o[i]}), 32'd0);
      check("rst_cs", 32'(scs[i]), 32'd0);
      check("rst_wen", 32'(swen[i]), 32'd0);
    end
    model_reset();
    @(posedge HCLK);
    #1;
    check("rst_hold_cs", 32'(scs[0]), 32'd0);
    HRESETn = 1'b1;
  endtask

  int exp_b4 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int exp_b1 [6]  = '{0, 1, 0, 1, 0, 1};

  initial begin
    for (int a = 0; a < 4096; a++) begin
      smem0[a] = 32'h0; smem1[a] = 32'h0;
      rmem[0][a] = 32'h0; rmem[1][a] = 32'h0;
    end
    bl[0] = 4;
    bl[1] = 1;
    model_reset();
    REQ0 = 0; REQ1 = 0; ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0; WEN0 = 0; WEN1 = 0;
    HRESETn = 1'b0;
    #2;
    check("reset_rvalid0", 32'(rv0_o[0]), 32'd0);
    check("reset_gnt", 32'({gnt0_o, gnt1_o}), 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    #2;

    // contention from reset: 4-burst rotation on one instance, strict alternation on the other
    for (int k = 0; k < 12; k++) begin
      step(1, 12'(k), 32'h0, 4'h0, 1, 12'(k + 100), 32'h0, 4'h0);
      check("burst4_seq", 32'(last_g[0]), 32'(exp_b4[k]));
      if (k < 6) check("burst1_seq", 32'(last_g[1]), 32'(exp_b1[k]));
    end
    idle(2);

    // port 0 alone: write then read back
    step(1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 12'h0, 32'h0, 4'h0);
    step(1, 12'h010, 32'h0, 4'h0, 0, 12'h0, 32'h0, 4'h0);
    check("p0_rdata", rd0_o[0], 32'hDEADBEEF);
    check("p0_rvalid1", 32'(rv1_o[0]), 32'd0);
    idle(2);

    // port 1 streams; a single-cycle port 0 request does not preempt before the quota
    step(0, 12'h0, 32'h0, 4'h0, 1, 12'h5, 32'h0, 4'h0);
    step(0, 12'h0, 32'h0, 4'h0, 1, 12'h5, 32'h0, 4'h0);
    step(1, 12'h6, 32'h0, 4'h0, 1, 12'h5, 32'h0, 4'h0);
    check("p1_keeps", 32'(last_g[0]), 32'd1);
    step(0, 12'h0, 32'h0, 4'h0, 1, 12'h5, 32'h0, 4'h0);
    step(1, 12'h6, 32'h0, 4'h0, 1, 12'h5, 32'h0, 4'h0);
    check("p0_after_burst", 32'(last_g[0]), 32'd0);
    idle(2);

    // byte-lane merge: preload, partial write from port 1, read from port 0
    step(1, 12'h020, 32'h11223344, 4'hF, 0, 12'h0, 32'h0, 4'h0);
    step(0, 12'h0, 32'h0, 4'h0, 1, 12'h020, 32'h0000AB00, 4'b0010);
    step(1, 12'h020, 32'h0, 4'h0, 0, 12'h0, 32'h0, 4'h0);
    check("byte_merge", rd0_o[0], 32'h1122AB44);
    idle(2);

    // reset right after a port 0 read grant, both requests held through reset
    step(1, 12'h010, 32'h0, 4'h0, 0, 12'h0, 32'h0, 4'h0);
    REQ1 = 1; ADDR1 = 12'h030; WEN1 = 4'h0;
    pulse_reset();
    step(1, 12'h010, 32'h0, 4'h0, 1, 12'h030, 32'h0, 4'h0);
    check("post_reset_first", 32'(last_g[0]), 32'd0);
    idle(1);

    // randomized traffic on a small address window, occasional reset
    for (int k = 0; k < 400; k++) begin
      logic [3:0] w0r, w1r;
      w0r = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      w1r = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 63) == 0) pulse_reset();
      step($urandom_range(0, 3) != 0, 12'($urandom_range(0, 15)), $urandom, w0r,
           $urandom_range(0, 3) != 0, 12'($urandom_range(0, 15)), $urandom, w1r);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sl_sram_arbiter.md
Name: sl_sram_arbiter

Overview:
- Two-requester arbiter that shares one single-port SRAM macro (sl_sram interface: ADDR, WDATA, WREN[3:0], CS, RDATA with 1-cycle read latency).
- Typical pairing: CPU-side AHB-to-SRAM bridge on port 0, DMA or accelerator SRAM interface on port 1.
- Round-robin arbitration with bounded burst tenure.
- Combinational grant; registered read-data return.

Parameters:
- AW, 12, SRAM word-address width (byte address width minus 2).
- DW, 32, data width; byte lanes = DW/8, fixed at 4 for 32.
- BURST_LEN, 4, maximum consecutive grants to one port while the other port is requesting (legal 1..15).

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- REQ0  in  1  port 0 request; held with payload until granted
- ADDR0  in  AW  port 0 word address
- WDATA0  in  DW  port 0 write data
- WEN0  in  4  port 0 byte write enables; 0000 = read
- GNT0  out  1  port 0 grant; transfer occurs in the cycle where REQ0 & GNT0
- RVALID0  out  1  port 0 read data valid
- RDATA0  out  DW  port 0 read data
- REQ1/ADDR1/WDATA1/WEN1/GNT1/RVALID1/RDATA1: same as port 0, for port 1
- SRAMADDR  out  AW  to SRAM
- SRAMWDATA  out  DW  to SRAM
- SRAMWEN  out  4  to SRAM
- SRAMCS  out  1  to SRAM
- SRAMRDATA  in  DW  from SRAM, valid the cycle after a CS read

Behaviour:
- State: FSM {IDLE, OWN0, OWN1}; burst counter cnt (4 bits); last_owner (1 bit).
- Reset values: IDLE, cnt = 0, last_owner = 1 (port 0 wins first tie), RVALID0/1 = 0.
- While HRESETn is low, force GNT0/1, SRAMCS and SRAMWEN to 0.
- Grant is combinational from REQx, state and cnt. At most one GNTx per cycle. A GNT is never raised without its REQ.
- Grant rule in IDLE:
  - Only one REQ: grant it.
  - Both REQ: grant the port != last_owner.
- Grant rule in OWNx:
  - REQx && (cnt < BURST_LEN || !REQy): grant x.
  - Else if REQy: grant y.
  - Else: no grant.
- Sequential update on a granted cycle to port g:
  - State -> OWNg; last_owner <= g.
  - cnt <= (g == previous owner) ? min(cnt+1, BURST_LEN) : 1.
- No grant: state -> IDLE; cnt <= 0; last_owner holds.
- SRAM drive:
  - SRAMCS = GNT0 | GNT1.
  - SRAMADDR, SRAMWDATA and SRAMWEN are muxed from the granted port.
  - With no grant: SRAMADDR/SRAMWDATA hold port 0 values (don't-care); SRAMWEN = 0.
- Read return:
  - A granted read (WENx == 0) sets RVALIDx = 1 for exactly the next cycle.
  - RDATAx = SRAMRDATA when RVALIDx, else all zeros.
  - Granted writes produce no RVALID.
- Throughput: one SRAM access per cycle. Back-to-back reads give RVALID on consecutive cycles, in grant order.
- BURST_LEN = 1: strict alternation under continuous contention.
- Reset mid-operation: a pending RVALID is dropped (cleared asynchronously), and a requester whose read was in flight must reissue it. REQs held through reset are arbitrated from IDLE on the first cycle after release.
- Requesters must not change payload while REQx && !GNTx. Violations are not checked.

Test Plan:
- Port 0 alone: write ADDR0 = 0x010, WDATA0 = 0xDEADBEEF, WEN0 = 1111, then read 0x010 -> GNT0 each cycle; RVALID0 one cycle after the read grant with RDATA0 = 0xDEADBEEF; RVALID1 stays 0.
- Simultaneous REQ0/REQ1 reads from IDLE after reset, both held for 12 cycles, BURST_LEN = 4 -> grants 0,0,0,0,1,1,1,1,0,0,0,0; SRAMCS = 1 every cycle; RVALIDs follow grants by one cycle.
- Port 1 holds a continuous request; port 0 requests for one cycle only, after port 1 has had 2 grants -> port 1 keeps the grant (cnt < 4). Port 0 raises REQ0 again and holds it -> port 0 is granted after at most 4 consecutive port 1 grants.
- Byte write WEN1 = 0010 with WDATA1 = 0x0000AB00 to a word preloaded with 0x11223344, then read from port 0 -> RDATA0 = 0x1122AB44.
- HRESETn asserted the cycle after a port 0 read grant -> RVALID0 = 0 immediately and GNT0/SRAMCS = 0 during reset. After release with REQ1 & REQ0 held -> port 0 granted first.
- BURST_LEN = 1 under continuous contention for 6 cycles -> grants 0,1,0,1,0,1.
